mem_stage_p: RTL and testbench

MEM_STAGE_P -- requirements
Module: mem_stage_p

---
 rtl/mem_stage_p.sv | 171 +++++++++++++++++
 tb/tb_mem_stage_p.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_p.sv
// MEM pipeline stage: word-organised data memory with byte/half/word access and optional wait states.
// Define MEM_STAGE_MISALIGN_TRAP_EN to trap misaligned accesses instead of forcing alignment.
module mem_stage_p #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [1:0]        size,
  input  logic              LoadSigned,
  input  logic              Overflow_in,
  input  logic [4:0]        rw_in,
  input  logic [DATA_W-1:0] Result_in,
  input  logic [31:0]       mem_addr,
  input  logic [DATA_W-1:0] busB,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] Dout,
  output logic [DATA_W-1:0] Result,
  output logic [4:0]        rw,
  output logic              Overflow,
  output logic              misalign
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [2:0] LAT3 = 3'(MEM_LAT);

  state_t            state, state_nx;
  logic [2:0]        cnt, cnt_nx;
  logic              mem_op, is_store, is_load, complete, mis, we;
  logic [1:0]        lane;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] rd_word, ld_data, st_data;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [3:0]        be;
  logic              unused_addr_bits;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // A simultaneous read+write request is a store.
  assign is_store = MemWr;
  assign is_load  = MemRd & ~MemWr;
  assign mem_op   = MemRd | MemWr;
  assign idx      = mem_addr[ADDR_W+1:2];
  assign rd_word  = mem[idx];
  assign unused_addr_bits = ^mem_addr[31:ADDR_W+2];

  always_comb begin
    lane = mem_addr[1:0];
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    mis = mem_op && (((size == 2'b01) && mem_addr[0]) ||
                     (size[1] && (mem_addr[1:0] != 2'b00)));
`else
    mis = 1'b0;
    if (size == 2'b01) lane[0] = 1'b0;
    else if (size[1])  lane    = 2'b00;
`endif
  end

  always_comb begin
    ld_byte = rd_word[{lane, 3'b000} +: 8];
    ld_half = rd_word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   ld_data = {{24{LoadSigned & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{LoadSigned & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (size)
      2'b00: begin
        be      = 4'b0001 << lane;
        st_data = {4{busB[7:0]}};
      end
      2'b01: begin
        be      = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{busB[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = busB;
      end
    endcase
  end

  // Zero latency bypasses the FSM: every accepted cycle completes at its own edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    complete = 1'b0;
    if (MEM_LAT == 0) begin
      complete = in_valid;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            if (mem_op) begin
              state_nx = S_WAIT;
              cnt_nx   = LAT3;
            end else begin
              complete = 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 3'd1) begin
            complete = 1'b1;
            state_nx = S_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - 3'd1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign stall = (state == S_WAIT);
  assign we    = complete & is_store & ~Overflow_in & ~mis & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid <= 1'b0;
      Dout     <= '0;
      Result   <= '0;
      rw       <= '0;
      Overflow <= 1'b0;
      misalign <= 1'b0;
    end else if (complete) begin
      wb_valid <= 1'b1;
      Dout     <= (is_load && !mis) ? ld_data : '0;
      Result   <= Result_in;
      rw       <= rw_in;
      Overflow <= Overflow_in;
      misalign <= mis;
    end else begin
      wb_valid <= 1'b0;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_p.sv
// Bench for mem_stage_p: three instances (0, 3, 4 wait states) checked against a byte-level memory model.
module tb_mem_stage_p;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sgn, ovf;
    logic [4:0]  rwi;
    logic [31:0] res, addr, data;
  } op_t;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  sz;
    logic        sgn, ovf;
    logic [31:0] addr, data, exp_dout;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    int          stalls;
    logic        wb_in_stall;
    logic        wb, ovf, mis;
    logic [31:0] dout, res;
    logic [4:0]  rw;
  } res_t;

  logic        clk = 1'b0;
  logic        rst, rst4;
  logic [2:0]  iv, rstv;
  logic        MemRd, MemWr, LoadSigned, Overflow_in;
  logic [1:0]  size;
  logic [4:0]  rw_in;
  logic [31:0] Result_in, mem_addr, busB;

  logic        stall_o [3];
  logic        wb_o    [3];
  logic        ovf_o   [3];
  logic        mis_o   [3];
  logic [31:0] dout_o  [3];
  logic [31:0] res_o   [3];
  logic [4:0]  rw_o    [3];

  logic [7:0]  refm [3][4096];
  logic [31:0] last_dout [3];
  logic [31:0] last_res  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rstv = {rst | rst4, rst, rst};

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_stage_p #(
      .DATA_W (32),
      .ADDR_W (10),
      .MEM_LAT((g == 0) ? 0 : (g == 1) ? 3 : 4)
    ) u_dut (
      .clk        (clk),
      .rst        (rstv[g]),
      .in_valid   (iv[g]),
      .MemRd      (MemRd),
      .MemWr      (MemWr),
      .size       (size),
      .LoadSigned (LoadSigned),
      .Overflow_in(Overflow_in),
      .rw_in      (rw_in),
      .Result_in  (Result_in),
      .mem_addr   (mem_addr),
      .busB       (busB),
      .stall      (stall_o[g]),
      .wb_valid   (wb_o[g]),
      .Dout       (dout_o[g]),
      .Result     (res_o[g]),
      .rw         (rw_o[g]),
      .Overflow   (ovf_o[g]),
      .misalign   (mis_o[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: memory as a byte array, accesses as little-endian byte runs.
  function automatic void model_op(input int d, input op_t o,
                                   output logic [31:0] dout, output logic mis);
    int          n;
    int unsigned a;
    longint      v;
    n    = (o.sz == 2'b00) ? 1 : (o.sz == 2'b01) ? 2 : 4;
    a    = o.addr[11:0];
    mis  = 1'b0;
    dout = '0;
    if ((o.rd || o.wr) && (a % n) != 0) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      mis = 1'b1;
`else
      a = a - (a % n);
`endif
    end
    if (o.wr) begin
      if (!o.ovf && !mis)
        for (int i = 0; i < n; i++) refm[d][a + i] = o.data[8*i +: 8];
    end else if (o.rd && !mis) begin
      v = 0;
      for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'(refm[d][a + i]);
      if (o.sgn && n < 4 && v >= (64'sd1 <<< (8*n - 1))) v = v - (64'sd1 <<< (8*n));
      dout = v[31:0];
    end
  endfunction

  task automatic run_op(input int d, input op_t o, output res_t r);
    MemRd = o.rd; MemWr = o.wr; size = o.sz; LoadSigned = o.sgn;
    Overflow_in = o.ovf; rw_in = o.rwi; Result_in = o.res;
    mem_addr = o.addr; busB = o.data;
    iv[d] = 1'b1;
    r.stalls = 0;
    r.wb_in_stall = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!stall_o[d]) break;
      r.stalls++;
      if (wb_o[d]) r.wb_in_stall = 1'b1;
    end
    iv[d] = 1'b0;
    r.wb = wb_o[d]; r.dout = dout_o[d]; r.res = res_o[d];
    r.rw = rw_o[d]; r.ovf = ovf_o[d]; r.mis = mis_o[d];
  endtask

  task automatic check_op(input string tag, input int d, input op_t o, input res_t r,
                          input logic [31:0] exp_dout, input logic exp_mis);
    chk({tag, " stall_cycles"}, r.stalls, (o.rd || o.wr) ? lat_of(d) : 0);
    chk({tag, " wb_in_stall"}, {31'b0, r.wb_in_stall}, 32'd0);
    chk({tag, " wb_valid"}, {31'b0, r.wb}, 32'd1);
    chk({tag, " Dout"}, r.dout, exp_dout);
    chk({tag, " Result"}, r.res, o.res);
    chk({tag, " rw"}, {27'b0, r.rw}, {27'b0, o.rwi});
    chk({tag, " Overflow"}, {31'b0, r.ovf}, {31'b0, o.ovf});
    chk({tag, " misalign"}, {31'b0, r.mis}, {31'b0, exp_mis});
    last_dout[d] = exp_dout;
    last_res[d]  = o.res;
  endtask

  task automatic model_run(input string tag, input int d, input op_t o);
    logic [31:0] ed;
    logic        em;
    res_t        r;
    model_op(d, o, ed, em);
    run_op(d, o, r);
    check_op(tag, d, o, r, ed, em);
  endtask

  task automatic idle_check(input int d);
    @(negedge clk);
    chk($sformatf("idle%0d wb_valid", d), {31'b0, wb_o[d]}, 32'd0);
    chk($sformatf("idle%0d Dout_hold", d), dout_o[d], last_dout[d]);
    chk($sformatf("idle%0d Result_hold", d), res_o[d], last_res[d]);
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic ovf,
                             input logic [31:0] addr, input logic [31:0] data);
    op_t o;
    o.rd = rd; o.wr = wr; o.sz = sz; o.sgn = sgn; o.ovf = ovf;
    o.addr = addr; o.data = data;
    o.rwi = 5'($urandom); o.res = $urandom;
    return o;
  endfunction

  function automatic vec_t V(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic sgn, input logic ovf, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] ed, input logic em);
    vec_t v;
    v.rd = rd; v.wr = wr; v.sz = sz; v.sgn = sgn; v.ovf = ovf;
    v.addr = addr; v.data = data; v.exp_dout = ed; v.exp_mis = em;
    return v;
  endfunction

  vec_t tbl [21];

  initial begin
    op_t         o;
    res_t        r;
    logic [31:0] ed;
    logic        em;
    logic        trap;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif

    tbl[0]  = V(0,1,2'b10,0,0,32'h10,32'h11223344,32'h0,0);
    tbl[1]  = V(1,0,2'b10,0,0,32'h10,32'h0,32'h11223344,0);
    tbl[2]  = V(0,1,2'b10,0,0,32'h10,32'h0,32'h0,0);
    tbl[3]  = V(0,1,2'b00,0,0,32'h13,32'hFFFFFFAB,32'h0,0);
    tbl[4]  = V(1,0,2'b00,1,0,32'h13,32'h0,32'hFFFFFFAB,0);
    tbl[5]  = V(1,0,2'b00,0,0,32'h13,32'h0,32'h000000AB,0);
    tbl[6]  = V(1,0,2'b10,0,0,32'h10,32'h0,32'hAB000000,0);
    tbl[7]  = V(0,1,2'b10,0,0,32'h20,32'h5A5A5A5A,32'h0,0);
    tbl[8]  = V(0,1,2'b10,0,1,32'h20,32'hDEADBEEF,32'h0,0);
    tbl[9]  = V(1,0,2'b10,0,0,32'h20,32'h0,32'h5A5A5A5A,0);
    tbl[10] = V(0,1,2'b01,0,0,32'h22,32'h1234BEEF,32'h0,0);
    tbl[11] = V(1,0,2'b01,1,0,32'h22,32'h0,32'hFFFFBEEF,0);
    tbl[12] = V(1,0,2'b01,0,0,32'h20,32'h0,32'h00005A5A,0);
    tbl[13] = V(1,0,2'b10,0,0,32'h20,32'h0,32'hBEEF5A5A,0);
    tbl[14] = V(0,1,2'b10,0,0,32'h22,32'hCAFEF00D,32'h0,trap);
    tbl[15] = V(1,0,2'b10,0,0,32'h20,32'h0,trap ? 32'hBEEF5A5A : 32'hCAFEF00D,0);
    tbl[16] = V(1,0,2'b10,0,0,32'hFFFFF010,32'h0,32'hAB000000,0);
    tbl[17] = V(1,1,2'b10,0,0,32'h14,32'h600DF00D,32'h0,0);
    tbl[18] = V(1,0,2'b10,0,0,32'h14,32'h0,32'h600DF00D,0);
    tbl[19] = V(1,0,2'b01,1,0,32'h13,32'h0,trap ? 32'h0 : 32'hFFFFAB00,trap);
    tbl[20] = V(0,0,2'b10,0,1,32'h20,32'h0,32'h0,0);

    rst = 1'b1; rst4 = 1'b0; iv = '0;
    MemRd = 0; MemWr = 0; size = 0; LoadSigned = 0; Overflow_in = 0;
    rw_in = 0; Result_in = 0; mem_addr = 0; busB = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst%0d stall", d), {31'b0, stall_o[d]}, 32'd0);
      chk($sformatf("rst%0d wb_valid", d), {31'b0, wb_o[d]}, 32'd0);
      chk($sformatf("rst%0d Dout", d), dout_o[d], 32'd0);
      chk($sformatf("rst%0d Result", d), res_o[d], 32'd0);
      chk($sformatf("rst%0d rw", d), {27'b0, rw_o[d]}, 32'd0);
      chk($sformatf("rst%0d Overflow", d), {31'b0, ovf_o[d]}, 32'd0);
      chk($sformatf("rst%0d misalign", d), {31'b0, mis_o[d]}, 32'd0);
      last_dout[d] = '0;
      last_res[d]  = '0;
    end
    rst = 1'b0;
    @(negedge clk);

    // Directed vectors on the zero-wait-state instance.
    for (int i = 0; i < 21; i++) begin
      o = mk(tbl[i].rd, tbl[i].wr, tbl[i].sz, tbl[i].sgn, tbl[i].ovf, tbl[i].addr, tbl[i].data);
      model_op(0, o, ed, em);
      run_op(0, o, r);
      check_op($sformatf("tbl%0d", i), 0, o, r, tbl[i].exp_dout, tbl[i].exp_mis);
    end
    idle_check(0);

    // Three wait states: load stalls three cycles, following ALU op does not.
    model_run("lat3 store", 1, mk(0,1,2'b10,0,0,32'h8,32'h0BADCAFE));
    idle_check(1);
    o = mk(1,0,2'b10,0,0,32'h8,32'h0);
    run_op(1, o, r);
    check_op("lat3 load", 1, o, r, 32'h0BADCAFE, 1'b0);
    refm[1][8] = 8'hFE; refm[1][9] = 8'hCA; refm[1][10] = 8'hAD; refm[1][11] = 8'h0B;
    o = mk(0,0,2'b00,0,0,32'h0,32'h0);
    run_op(1, o, r);
    check_op("lat3 alu", 1, o, r, 32'h0, 1'b0);
    idle_check(1);

    // Reset during the second wait cycle abandons the store.
    model_run("lat4 init", 2, mk(0,1,2'b10,0,0,32'h30,32'h77777777));
    MemRd = 0; MemWr = 1; size = 2'b10; Overflow_in = 0; mem_addr = 32'h30;
    busB = 32'h12345678; Result_in = 32'h13572468; rw_in = 5'd9;
    iv[2] = 1'b1;
    @(negedge clk);
    chk("lat4 wait1 stall", {31'b0, stall_o[2]}, 32'd1);
    @(negedge clk);
    chk("lat4 wait2 stall", {31'b0, stall_o[2]}, 32'd1);
    rst4 = 1'b1;
    #1;
    chk("lat4 rst stall", {31'b0, stall_o[2]}, 32'd0);
    chk("lat4 rst wb_valid", {31'b0, wb_o[2]}, 32'd0);
    chk("lat4 rst Result", res_o[2], 32'd0);
    chk("lat4 rst Dout", dout_o[2], 32'd0);
    @(negedge clk);
    iv[2] = 1'b0;
    rst4 = 1'b0;
    last_dout[2] = '0;
    last_res[2]  = '0;
    idle_check(2);
    model_run("lat4 reload", 2, mk(1,0,2'b10,0,0,32'h30,32'h0));

    // Randomised traffic on the 0- and 3-wait-state instances.
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 16; w++)
        model_run($sformatf("init%0d_%0d", d, w), d,
                  mk(0,1,2'b10,0,0,32'h40 + 32'(4*w),$urandom));
      for (int k = 0; k < 80; k++) begin
        o = mk(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
               ($urandom_range(0,7) == 0),
               ($urandom << 12) | (32'h40 + 32'($urandom_range(0,63))), $urandom);
        model_run($sformatf("rnd%0d_%0d", d, k), d, o);
        if ($urandom_range(0,4) == 0) idle_check(d);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
